uart_tx: RTL and testbench

UART transmit serializer that consumes the one-cycle baud tick produced by the UART baud accumulator and shifts framed bytes onto `tx_o`. It accepts bytes from the host side over a valid/ready handshake into a one-entry holding register. This allows the next byte to be queued while the current frame is on the line, so frames go out back-to-back with no idle gap.

---
 rtl/uart_tx.sv | 148 ++++++++++++++
 tb/tb_uart_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmit serializer with a one-entry holding register and optional parity.
// Define UART_TX_TWO_STOP_EN to append a second stop bit to every frame.
module uart_tx #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 baud_tick_i,
  input  logic                 tx_en,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 data_order,
  input  logic                 polarity,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int unsigned CntW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
`ifdef UART_TX_TWO_STOP_EN
    StStop2,
`endif
    StStop
  } state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] hold_q;
  logic                 hold_v;
  logic [DATA_BITS-1:0] shift_q, shift_d, shifted;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 par_en_q, par_bit_q, order_q;
  logic                 line_q, line_d;
  logic                 busy_q;
  logic                 load, can_load;

  assign can_load = hold_v & tx_en;
  assign shifted  = order_q ? (shift_q << 1) : (shift_q >> 1);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    load    = 1'b0;
    if (baud_tick_i) begin
      unique case (state_q)
        StIdle: begin
          if (can_load) begin
            load    = 1'b1;
            shift_d = hold_q;
            state_d = StStart;
            line_d  = 1'b0;
          end
        end
        StStart: begin
          state_d = StData;
          cnt_d   = '0;
          line_d  = order_q ? shift_q[DATA_BITS-1] : shift_q[0];
        end
        StData: begin
          if (cnt_q < LastCnt) begin
            cnt_d   = cnt_q + 1'b1;
            shift_d = shifted;
            line_d  = order_q ? shifted[DATA_BITS-1] : shifted[0];
          end else if (par_en_q) begin
            state_d = StParity;
            line_d  = par_bit_q;
          end else begin
            state_d = StStop;
            line_d  = 1'b1;
          end
        end
        StParity: begin
          state_d = StStop;
          line_d  = 1'b1;
        end
`ifdef UART_TX_TWO_STOP_EN
        StStop: begin
          state_d = StStop2;
          line_d  = 1'b1;
        end
        StStop2: begin
`else
        StStop: begin
`endif
          // Last stop bit: chain straight into the next frame when one is queued.
          if (can_load) begin
            load    = 1'b1;
            shift_d = hold_q;
            state_d = StStart;
            line_d  = 1'b0;
          end else begin
            state_d = StIdle;
            line_d  = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          line_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      hold_v    <= 1'b0;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      order_q   <= 1'b0;
      line_q    <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      busy_q  <= (state_d != StIdle);
      if (load) begin
        hold_v    <= 1'b0;
        par_en_q  <= parity_en;
        order_q   <= data_order;
        par_bit_q <= (^hold_q) ^ parity_odd;
      end else if (valid_i && !hold_v) begin
        hold_v <= 1'b1;
        hold_q <= data_i;
      end
    end
  end

  assign ready_o = ~hold_v;
  assign busy_o  = busy_q;
  assign tx_o    = line_q ^ polarity;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: constant frame vectors, corner sequences and
// randomized batches checked against a bit-list frame model.
module tb_uart_tx;

  localparam int DB = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int StopBits = 2;
`else
  localparam int StopBits = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i, baud_tick_i, tx_en, parity_en, parity_odd, data_order, polarity;
  logic          valid_i, ready_o, tx_o, busy_o;
  logic [DB-1:0] data_i;

  uart_tx #(.DATA_BITS(DB)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .baud_tick_i(baud_tick_i),
    .tx_en      (tx_en),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .data_order (data_order),
    .polarity   (polarity),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .tx_o       (tx_o),
    .busy_o     (busy_o)
  );

  int checks = 0;
  int errors = 0;
  int tick_per = 16;
  int phase = 0;
  bit ticking = 1'b0;
  int glitches = 0;
  logic prev_tx, prev_pol;

  logic [DB-1:0] send_q[$];
  logic line_log[$];
  logic busy_log[$];
  logic ready_log[$];
  logic exp_bits[$];

  typedef struct {
    logic [7:0]  d;
    bit          pe;
    bit          po;
    bit          ord;
    int          len;
    logic [15:0] bits;  // first line bit at position len-1
  } vec_t;
  vec_t vecs[5];

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // One clock: drive tick and handshake at negedge, sample 1 ns after posedge.
  task automatic cycle();
    logic rdy, tick;
    @(negedge clk);
    tick = ticking && (phase == tick_per - 1);
    phase = (phase >= tick_per - 1) ? 0 : phase + 1;
    baud_tick_i = tick;
    if (send_q.size() > 0) begin
      valid_i = 1'b1;
      data_i  = send_q[0];
    end else begin
      valid_i = 1'b0;
    end
    rdy = ready_o;
    @(posedge clk);
    #1;
    if (valid_i && rdy) void'(send_q.pop_front());
    if (tick) begin
      line_log.push_back(tx_o ^ polarity);
      busy_log.push_back(busy_o);
      ready_log.push_back(ready_o);
    end
    if (tx_o !== prev_tx && !tick && !rst_i && polarity === prev_pol) glitches++;
    prev_tx  = tx_o;
    prev_pol = polarity;
  endtask

  task automatic clear_logs();
    line_log.delete();
    busy_log.delete();
    ready_log.delete();
    exp_bits.delete();
  endtask

  task automatic add_frame(logic [DB-1:0] d, bit pe, bit po, bit ord);
    int ones = 0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) begin
      exp_bits.push_back(d[ord ? DB - 1 - i : i]);
      if (d[i]) ones++;
    end
    if (pe) exp_bits.push_back(((ones % 2) != 0) ^ po);
    for (int i = 0; i < StopBits; i++) exp_bits.push_back(1'b1);
  endtask

  task automatic timeout(string name);
    checks++;
    errors++;
    $display("FAIL %s timeout waiting for DUT", name);
  endtask

  task automatic wait_busy(string name);
    int n = 0;
    while (!busy_o && n < 2000) begin
      cycle();
      n++;
    end
    if (!busy_o) timeout(name);
  endtask

  task automatic run_until_idle(string name);
    bit seen = 1'b0;
    bit done = 1'b0;
    for (int n = 0; n < 4000 && !done; n++) begin
      cycle();
      if (busy_o) seen = 1'b1;
      if (seen && !busy_o && ready_o && send_q.size() == 0) done = 1'b1;
    end
    if (!done) timeout(name);
    repeat (2 * tick_per + 2) cycle();
  endtask

  // Locate the first start bit; everything after must match exp_bits then idle marks.
  task automatic compare_log(string name, output int s);
    int mism = 0;
    s = -1;
    for (int i = 0; i < line_log.size() && s < 0; i++) if (!line_log[i]) s = i;
    if (s < 0) begin
      mism = exp_bits.size();
    end else begin
      for (int i = s; i < line_log.size(); i++) begin
        logic e;
        e = (i - s < exp_bits.size()) ? exp_bits[i - s] : 1'b1;
        if (line_log[i] !== e) mism++;
      end
      if (line_log.size() - s < exp_bits.size())
        mism += exp_bits.size() - (line_log.size() - s);
    end
    check({name, "_bit_mismatches"}, mism, 0);
  endtask

  function automatic int at_busy(int k);
    return (k >= 0 && k < busy_log.size()) ? int'(busy_log[k]) : 2;
  endfunction

  function automatic int at_ready(int k);
    return (k >= 0 && k < ready_log.size()) ? int'(ready_log[k]) : 2;
  endfunction

  initial begin
    int s, flen, zeros, nb;
    logic [DB-1:0] d;
    bit pe, po, ord;

    vecs[0] = '{d: 8'hA3, pe: 0, po: 0, ord: 0, len: 10, bits: 16'b0110001011};
    vecs[1] = '{d: 8'hA3, pe: 1, po: 0, ord: 1, len: 11, bits: 16'b01010001101};
    vecs[2] = '{d: 8'hA3, pe: 1, po: 1, ord: 1, len: 11, bits: 16'b01010001111};
    vecs[3] = '{d: 8'h55, pe: 0, po: 0, ord: 0, len: 10, bits: 16'b0101010101};
    vecs[4] = '{d: 8'h0F, pe: 1, po: 0, ord: 0, len: 11, bits: 16'b01111000001};

    rst_i = 1'b1; baud_tick_i = 1'b0; tx_en = 1'b1; parity_en = 1'b0; parity_odd = 1'b0;
    data_order = 1'b0; polarity = 1'b0; valid_i = 1'b0; data_i = '0;
    prev_tx = 1'b1; prev_pol = 1'b0;
    repeat (3) cycle();
    check("reset_tx", int'(tx_o), 1);
    check("reset_ready", int'(ready_o), 1);
    check("reset_busy", int'(busy_o), 0);
    polarity = 1'b1;
    #1;
    check("reset_tx_inverted", int'(tx_o), 0);
    polarity = 1'b0;
    #1;
    rst_i = 1'b0;
    ticking = 1'b1;
    tick_per = 16;
    phase = 0;
    repeat (4) cycle();

    // Constant frame vectors, ticks every 16 clocks.
    for (int v = 0; v < 5; v++) begin
      parity_en = vecs[v].pe; parity_odd = vecs[v].po; data_order = vecs[v].ord;
      clear_logs();
      for (int i = 0; i < vecs[v].len; i++) exp_bits.push_back(vecs[v].bits[vecs[v].len - 1 - i]);
      for (int i = 1; i < StopBits; i++) exp_bits.push_back(1'b1);
      send_q.push_back(vecs[v].d);
      run_until_idle($sformatf("vec%0d", v));
      compare_log($sformatf("vec%0d", v), s);
      check($sformatf("vec%0d_busy_last_stop", v), at_busy(s + exp_bits.size() - 1), 1);
      check($sformatf("vec%0d_busy_after", v), at_busy(s + exp_bits.size()), 0);
    end

    // Back-to-back 0x55 then 0x0F.
    parity_en = 1'b0; data_order = 1'b0;
    flen = 1 + DB + StopBits;
    clear_logs();
    add_frame(8'h55, 0, 0, 0);
    add_frame(8'h0F, 0, 0, 0);
    send_q.push_back(8'h55);
    send_q.push_back(8'h0F);
    run_until_idle("b2b");
    compare_log("b2b", s);
    check("b2b_ready_queued", at_ready(s + flen - 1), 0);
    check("b2b_ready_after_load", at_ready(s + flen), 1);
    check("b2b_busy_between", at_busy(s + flen), 1);

    // tx_en dropped mid-frame: first frame completes, queued byte waits.
    clear_logs();
    add_frame(8'h55, 0, 0, 0);
    send_q.push_back(8'h55);
    send_q.push_back(8'h0F);
    wait_busy("txen_start");
    repeat (3 * tick_per) cycle();
    tx_en = 1'b0;
    for (int n = 0; n < 4000 && busy_o; n++) cycle();
    repeat (3 * tick_per) cycle();
    compare_log("txen_first", s);
    check("txen_ready_held", int'(ready_o), 0);
    check("txen_line_idle", int'(tx_o), 1);
    clear_logs();
    add_frame(8'h0F, 0, 0, 0);
    tx_en = 1'b1;
    run_until_idle("txen_resume");
    compare_log("txen_resume", s);
    check("txen_resume_first_tick", s, 0);

    // Reset mid-data with a byte queued.
    clear_logs();
    send_q.push_back(8'h55);
    send_q.push_back(8'h0F);
    wait_busy("rst_start");
    repeat (3 * tick_per) cycle();
    check("rst_queued_before", int'(ready_o), 0);
    rst_i = 1'b1;
    cycle();
    check("rst_tx", int'(tx_o), 1);
    check("rst_busy", int'(busy_o), 0);
    check("rst_ready", int'(ready_o), 1);
    rst_i = 1'b0;
    clear_logs();
    repeat (14 * tick_per) cycle();
    zeros = 0;
    foreach (line_log[i]) if (!line_log[i]) zeros++;
    check("rst_discard_zero_bits", zeros, 0);

    // Randomized batches: settings, polarity, tick period and byte count vary.
    for (int b = 0; b < 12; b++) begin
      tick_per = $urandom_range(1, 6);
      phase = 0;
      pe = 1'($urandom); po = 1'($urandom); ord = 1'($urandom);
      parity_en = pe; parity_odd = po; data_order = ord;
      polarity = 1'($urandom);
      repeat (2) cycle();
      clear_logs();
      nb = $urandom_range(1, 4);
      for (int i = 0; i < nb; i++) begin
        d = DB'($urandom);
        send_q.push_back(d);
        add_frame(d, pe, po, ord);
      end
      run_until_idle($sformatf("rand%0d", b));
      compare_log($sformatf("rand%0d", b), s);
    end

    check("level_changes_without_tick", glitches, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
